// File: rtl/axi_gpio_pkg.sv
// Shared definitions for the AXI4 GPIO slave: register offsets, burst and
// response encodings, channel FSM states and the burst address step helper.
package axi_gpio_pkg;

  localparam logic [3:0] LED_OFF        = 4'h0;
  localparam logic [3:0] SW_OFF         = 4'h4;
  localparam logic [3:0] IRQ_STATUS_OFF = 4'h8;
  localparam logic [3:0] IRQ_ENABLE_OFF = 4'hC;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  // Register index step for the next beat: FIXED holds, everything else
  // (INCR, WRAP, reserved) advances and wraps modulo 4 inside the window.
  function automatic logic [1:0] step_idx(input logic [1:0] idx, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? idx : idx + 2'd1;
  endfunction

endpackage

// File: rtl/axi_gpio_slave_debounce.sv
// Two-flop switch synchronizer with optional per-bit debounce.
// Macro GPIO_DEBOUNCE_EN enables the debounce counters; otherwise the
// output is the raw synchronizer output.
module gpio_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sw_async_i,
  output logic [WIDTH-1:0] sw_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_async_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Per-bit counter runs while the synchronized bit differs from the
  // accepted value; a toggle back clears it, so the run must be unbroken.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sw_o = stable_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign sw_o       = sync2_q;
`endif

endmodule

// File: rtl/axi_gpio_slave.sv
// AXI4 GPIO slave: LED register, synchronized switches, W1C switch-change
// interrupt status with enable mask and a registered level interrupt.
// Independent read and write channel FSMs supporting FIXED/INCR bursts.
// Macro GPIO_DEBOUNCE_EN enables switch debouncing (DEBOUNCE_CYCLES).
module axi_gpio_slave
  import axi_gpio_pkg::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter int ID_WIDTH        = 4,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [3:0]            s_axi_awregion,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [3:0]            s_axi_arregion,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           s_axi_rdata,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic                  s_axi_rlast,
  output logic [1:0]            s_axi_rresp,
  input  logic [15:0]           slide_switches,
  output logic [15:0]           leds,
  output logic                  irq
);

  logic rst_done_q;

  // Register file
  logic [15:0] led_q, led_d, ien_q, ien_d, ista_q, ista_d, sw_prev_q;
  logic [15:0] sw_sync, ista_clr, smask;
  logic        irq_q;

  // Write channel
  wstate_e               wstate_q, wstate_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [ADDR_WIDTH-1:2] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [1:0]            wburst_q, wburst_d;
  logic [8:0]            wcnt_q, wcnt_d;
  logic                  werr_q, werr_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_hs, w_hs, wbeat_err, wr_en;

  // Read channel
  rstate_e               rstate_q, rstate_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:2] raddr_q, raddr_d, rd_addr;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
  logic [31:0]           rdata_q, rdata_d, rd_val;
  logic                  rlast_q, rlast_d, ar_hs, rd_load;

  gpio_debounce #(
    .WIDTH           (16),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .sw_async_i (slide_switches),
    .sw_o       (sw_sync)
  );

  assign s_axi_awready = rst_done_q && (wstate_q == W_IDLE);
  assign s_axi_wready  = (wstate_q == W_DATA);
  assign s_axi_bvalid  = (wstate_q == W_RESP);
  assign s_axi_bid     = wid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = rst_done_q && (rstate_q == R_IDLE);
  assign s_axi_rvalid  = (rstate_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = s_axi_rvalid && rlast_q;
  assign leds          = led_q;
  assign irq           = irq_q;

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign ar_hs     = s_axi_arvalid && s_axi_arready;
  assign wbeat_err = |waddr_q[ADDR_WIDTH-1:4];
  assign smask     = {{8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};

  // Write FSM next state: capture AW, consume W beats, hold B until accepted
  always_comb begin
    wstate_d = wstate_q;
    wid_d    = wid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wburst_d = wburst_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    bresp_d  = bresp_q;
    wr_en    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          wid_d    = s_axi_awid;
          waddr_d  = s_axi_awaddr[ADDR_WIDTH-1:2];
          wlen_d   = s_axi_awlen;
          wburst_d = s_axi_awburst;
          wcnt_d   = '0;
          werr_d   = 1'b0;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          wr_en   = !wbeat_err;
          werr_d  = werr_q || wbeat_err;
          wcnt_d  = wcnt_q + 9'd1;
          waddr_d = {waddr_q[ADDR_WIDTH-1:4], step_idx(waddr_q[3:2], wburst_q)};
          if (s_axi_wlast) begin
            bresp_d  = (werr_q || wbeat_err || (wcnt_q != {1'b0, wlen_q}))
                       ? RESP_SLVERR : RESP_OKAY;
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Register updates: strobed writes, W1C clear, hardware set has priority
  always_comb begin
    led_d    = led_q;
    ien_d    = ien_q;
    ista_clr = '0;
    if (wr_en) begin
      case ({waddr_q[3:2], 2'b00})
        LED_OFF:        led_d    = (led_q & ~smask) | (s_axi_wdata[15:0] & smask);
        IRQ_STATUS_OFF: ista_clr = s_axi_wdata[15:0] & smask;
        IRQ_ENABLE_OFF: ien_d    = (ien_q & ~smask) | (s_axi_wdata[15:0] & smask);
        default: ;
      endcase
    end
    ista_d = (ista_q & ~ista_clr) | (sw_sync ^ sw_prev_q);
  end

  // Read FSM next state; beat data is registered from current register values
  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rburst_d = rburst_q;
    rcnt_d   = rcnt_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rd_addr  = raddr_q;
    rd_load  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rid_d    = s_axi_arid;
          raddr_d  = s_axi_araddr[ADDR_WIDTH-1:2];
          rlen_d   = s_axi_arlen;
          rburst_d = s_axi_arburst;
          rcnt_d   = '0;
          rlast_d  = (s_axi_arlen == 8'd0);
          rd_addr  = s_axi_araddr[ADDR_WIDTH-1:2];
          rd_load  = 1'b1;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            rstate_d = R_IDLE;
          end else begin
            rd_addr = {raddr_q[ADDR_WIDTH-1:4], step_idx(raddr_q[3:2], rburst_q)};
            raddr_d = rd_addr;
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
            rd_load = 1'b1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    rd_val = '0;
    case ({rd_addr[3:2], 2'b00})
      LED_OFF:        rd_val = {16'h0000, led_q};
      SW_OFF:         rd_val = {16'h0000, sw_sync};
      IRQ_STATUS_OFF: rd_val = {16'h0000, ista_q};
      IRQ_ENABLE_OFF: rd_val = {16'h0000, ien_q};
      default: ;
    endcase
    if (rd_load) begin
      if (|rd_addr[ADDR_WIDTH-1:4]) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else begin
        rdata_d = rd_val;
        rresp_d = RESP_OKAY;
      end
    end
  end

  // All state registers; everything clears on reset, aborting any burst
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_done_q <= 1'b0;
      led_q      <= '0;
      ien_q      <= '0;
      ista_q     <= '0;
      sw_prev_q  <= '0;
      irq_q      <= 1'b0;
      wstate_q   <= W_IDLE;
      wid_q      <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wburst_q   <= '0;
      wcnt_q     <= '0;
      werr_q     <= 1'b0;
      bresp_q    <= '0;
      rstate_q   <= R_IDLE;
      rid_q      <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rburst_q   <= '0;
      rcnt_q     <= '0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      rst_done_q <= 1'b1;
      led_q      <= led_d;
      ien_q      <= ien_d;
      ista_q     <= ista_d;
      sw_prev_q  <= sw_sync;
      irq_q      <= |(ista_q & ien_q);
      wstate_q   <= wstate_d;
      wid_q      <= wid_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wburst_q   <= wburst_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
      bresp_q    <= bresp_d;
      rstate_q   <= rstate_d;
      rid_q      <= rid_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rburst_q   <= rburst_d;
      rcnt_q     <= rcnt_d;
      rlast_q    <= rlast_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, s_axi_arsize, s_axi_awregion, s_axi_arregion,
                       s_axi_awcache, s_axi_arcache, s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[1:0], s_axi_araddr[1:0],
                       s_axi_wdata[31:16], s_axi_wstrb[3:2]};

endmodule

// File: tb/tb_axi_gpio_slave.sv
// Self-checking bench for axi_gpio_slave: directed scenarios followed by
// randomized transactions against a register-level reference model.
module tb_axi_gpio_slave;

  logic        clk, resetn;
  logic        s_axi_awvalid, s_axi_awready;
  logic [11:0] s_axi_awaddr;
  logic [3:0]  s_axi_awid;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic [3:0]  s_axi_awregion, s_axi_awcache;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [11:0] s_axi_araddr;
  logic [3:0]  s_axi_arid;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic [3:0]  s_axi_arregion, s_axi_arcache;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [3:0]  s_axi_rid;
  logic        s_axi_rlast;
  logic [1:0]  s_axi_rresp;
  logic [15:0] slide_switches, leds;
  logic        irq;

  axi_gpio_slave #(.ADDR_WIDTH(12), .ID_WIDTH(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awregion(s_axi_awregion), .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arregion(s_axi_arregion), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rid(s_axi_rid), .s_axi_rlast(s_axi_rlast), .s_axi_rresp(s_axi_rresp),
    .slide_switches(slide_switches), .leds(leds), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference model: architectural register contents
  logic [15:0] m_led, m_ien, m_ista, m_sw;
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [15:0] r;
    r = old;
    if (s[0]) r[7:0]  = d[7:0];
    if (s[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    d = 32'h0;
    r = 2'b00;
    if (a[11:4] != 8'h00) r = 2'b10;
    else if (a[3:2] == 2'd0) d = {16'h0, m_led};
    else if (a[3:2] == 2'd1) d = {16'h0, m_sw};
    else if (a[3:2] == 2'd2) d = {16'h0, m_ista};
    else d = {16'h0, m_ien};
  endtask

  function automatic logic [11:0] next_addr(input logic [11:0] a, input logic [1:0] burst);
    logic [11:0] n;
    n = a;
    if (burst != 2'b00) n[3:2] = a[3:2] + 2'd1;
    return n;
  endfunction

  task automatic do_aw(input logic [11:0] addr, input int unsigned len,
                       input logic [1:0] burst, input logic [3:0] id);
    s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awburst = burst; s_axi_awid = id;
    s_axi_awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_axi_awready) break;
    end
    if (!s_axi_awready) chk("aw_timeout", 32'(s_axi_awready), 32'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic do_b(input logic [3:0] id, input logic [1:0] exp_resp);
    s_axi_bready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_axi_bvalid) break;
    end
    chk("bvalid", 32'(s_axi_bvalid), 32'd1);
    chk("bresp", 32'(s_axi_bresp), 32'(exp_resp));
    chk("bid", 32'(s_axi_bid), 32'(id));
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  // Burst write using wbuf/sbuf; model updated beat by beat
  task automatic axi_write(input logic [11:0] addr, input int unsigned len,
                           input logic [1:0] burst, input logic [3:0] id);
    logic [11:0] a;
    logic        err_any;
    a = addr;
    err_any = 1'b0;
    do_aw(addr, len, burst, id);
    for (int unsigned b = 0; b <= len; b++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[b]; s_axi_wstrb = sbuf[b];
      s_axi_wlast = (b == len);
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (s_axi_wready) break;
      end
      if (!s_axi_wready) chk("w_timeout", 32'(s_axi_wready), 32'd1);
      @(posedge clk); #1;
      if (a[11:4] != 8'h00) err_any = 1'b1;
      else if (a[3:2] == 2'd0) m_led = merge(m_led, wbuf[b], sbuf[b]);
      else if (a[3:2] == 2'd2) m_ista = m_ista & ~merge(16'h0, wbuf[b], sbuf[b]);
      else if (a[3:2] == 2'd3) m_ien = merge(m_ien, wbuf[b], sbuf[b]);
      a = next_addr(a, burst);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    do_b(id, err_any ? 2'b10 : 2'b00);
  endtask

  task automatic axi_read(input logic [11:0] addr, input int unsigned len,
                          input logic [1:0] burst, input logic [3:0] id, input bit b2b);
    logic [11:0] a;
    logic [31:0] ed;
    logic [1:0]  er;
    int          waits;
    a = addr;
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arburst = burst; s_axi_arid = id;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_axi_arready) break;
    end
    if (!s_axi_arready) chk("ar_timeout", 32'(s_axi_arready), 32'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    for (int unsigned b = 0; b <= len; b++) begin
      waits = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (s_axi_rvalid) break;
        waits++;
      end
      if (b2b) chk("r_beat_gap", 32'(waits), 32'd0);
      model_read(a, ed, er);
      chk("rvalid", 32'(s_axi_rvalid), 32'd1);
      chk("rdata", s_axi_rdata, ed);
      chk("rresp", 32'(s_axi_rresp), 32'(er));
      chk("rlast", 32'(s_axi_rlast), 32'(b == len));
      chk("rid", 32'(s_axi_rid), 32'(id));
      @(posedge clk); #1;
      a = next_addr(a, burst);
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic set_sw(input logic [15:0] v);
    slide_switches = v;
    repeat (6) @(posedge clk);
    #1;
    m_ista = m_ista | (m_sw ^ v);
    m_sw   = v;
  endtask

  initial begin
    logic [11:0] ra;
    int unsigned op, len;
    logic [1:0]  br;
    resetn = 1'b0;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awregion = '0;
    s_axi_awcache = '0; s_axi_awprot = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
    s_axi_bready = 0;
    s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arregion = '0;
    s_axi_arcache = '0; s_axi_arprot = '0;
    s_axi_rready = 0; slide_switches = '0;
    m_led = '0; m_ien = '0; m_ista = '0; m_sw = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    resetn = 1'b1;
    #1;
    chk("rel_awready_low", 32'(s_axi_awready), 32'd0);
    @(posedge clk); #1;
    chk("rel_awready_high", 32'(s_axi_awready), 32'd1);
    chk("rel_arready_high", 32'(s_axi_arready), 32'd1);

    // Single writes with byte strobes
    wbuf[0] = 32'h0000A5A5; sbuf[0] = 4'hF;
    axi_write(12'h000, 0, 2'b01, 4'd5);
    chk("leds_a5a5", 32'(leds), 32'h0000A5A5);
    wbuf[0] = 32'h00FF00FF; sbuf[0] = 4'h1;
    axi_write(12'h000, 0, 2'b01, 4'd6);
    chk("leds_a5ff", 32'(leds), 32'h0000A5FF);

    // INCR read of the whole map with back-to-back beats
    axi_read(12'h000, 3, 2'b01, 4'd9, 1'b1);

    // FIXED write burst to IRQ_ENABLE
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
    sbuf[0] = 4'hF;  sbuf[1] = 4'hF;  sbuf[2] = 4'hF;
    axi_write(12'h00C, 2, 2'b00, 4'd3);
    axi_read(12'h00C, 0, 2'b01, 4'd1, 1'b0);

    // Interrupt: enable bit 0, toggle switch 0, exact latency
    wbuf[0] = 32'h1; sbuf[0] = 4'hF;
    axi_write(12'h00C, 0, 2'b01, 4'd2);
    slide_switches[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_not_yet", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_rise", 32'(irq), 32'd1);
    m_sw[0] = 1'b1; m_ista[0] = 1'b1;
    wbuf[0] = 32'h1; sbuf[0] = 4'hF;
    axi_write(12'h008, 0, 2'b01, 4'd2);
    @(posedge clk); #1;
    chk("irq_cleared", 32'(irq), 32'd0);

    // Switch toggle whose status set lands on the same edge as a W1C
    do_aw(12'h008, 0, 2'b01, 4'd7);
    slide_switches[0] = ~slide_switches[0];
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
    @(negedge clk);
    chk("wready_coincide", 32'(s_axi_wready), 32'd1);
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    m_sw[0] = ~m_sw[0]; m_ista[0] = 1'b1;
    do_b(4'd7, 2'b00);
    axi_read(12'h008, 0, 2'b01, 4'd7, 1'b0);
    @(posedge clk); #1;
    chk("irq_set_wins", 32'(irq), 32'd1);

    // Decode errors
    axi_read(12'h020, 0, 2'b01, 4'd4, 1'b0);
    wbuf[0] = 32'h00001234; sbuf[0] = 4'hF;
    axi_write(12'h020, 0, 2'b01, 4'd4);
    chk("leds_err_unchanged", 32'(leds), 32'(m_led));

    // Randomized transactions against the model
    for (int unsigned it = 0; it < 40; it++) begin
      op  = $urandom_range(0, 9);
      len = $urandom_range(0, 3);
      br  = 2'($urandom_range(0, 2));
      ra  = 12'($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 7) == 0) ra = ra | 12'h020;
      if (op < 2) begin
        set_sw(16'($urandom));
      end else if (op < 6) begin
        for (int unsigned b = 0; b < 4; b++) begin
          wbuf[b] = $urandom;
          sbuf[b] = 4'($urandom_range(0, 15));
        end
        axi_write(ra, len, br, 4'($urandom_range(0, 15)));
      end else begin
        axi_read(ra, len, br, 4'($urandom_range(0, 15)), 1'b1);
      end
      @(posedge clk); #1;
      chk("rand_leds", 32'(leds), 32'(m_led));
      chk("rand_irq", 32'(irq), 32'(|(m_ista & m_ien)));
    end

    // Reset in the middle of a read burst
    set_sw(16'h0000);
    s_axi_araddr = 12'h000; s_axi_arlen = 8'd3; s_axi_arburst = 2'b01; s_axi_arid = 4'd8;
    s_axi_arvalid = 1'b1;
    @(negedge clk);
    chk("mid_arready", 32'(s_axi_arready), 32'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    chk("mid_rvalid_before", 32'(s_axi_rvalid), 32'd1);
    resetn = 1'b0;
    #2;
    chk("mid_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("mid_leds", 32'(leds), 32'd0);
    chk("mid_irq", 32'(irq), 32'd0);
    m_led = '0; m_ien = '0; m_ista = '0; m_sw = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_arready", 32'(s_axi_arready), 32'd1);
    chk("post_rvalid", 32'(s_axi_rvalid), 32'd0);
    axi_read(12'h000, 0, 2'b01, 4'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_gpio_slave.md
# axi_gpio_slave

AXI4 slave GPIO peripheral attached to the Veronica SoC `m_axi_*` master port on the Nexys A7-100T top level. It drives the 16 board LEDs and samples the 16 slide switches through a two-flop synchronizer. It latches switch changes into a write-1-to-clear interrupt status register and raises a level interrupt toward `io_irq`. It supports INCR and FIXED bursts with independent read and write channels.

## Interface
- `ADDR_WIDTH`, 12: slave address window width; offsets ≥ 0x10 are undecoded.
- `ID_WIDTH`, 4: AXI ID width.
- `DEBOUNCE_CYCLES`, 65536: consecutive stable cycles required per switch; used only with `GPIO_DEBOUNCE_EN`.
- `clk` in 1: sole clock, AXI clock domain.
- `resetn` in 1: asynchronous, active-low reset.
- `s_axi_awvalid`/`s_axi_arvalid` in 1; `s_axi_awready`/`s_axi_arready` out 1: address handshakes.
- `s_axi_awaddr`/`s_axi_araddr` in ADDR_WIDTH: byte address; bits [1:0] ignored.
- `s_axi_awid`/`s_axi_arid` in ID_WIDTH: transaction ID.
- `s_axi_awlen`/`s_axi_arlen` in 8: beats minus one.
- `s_axi_awsize`/`s_axi_arsize` in 3: ignored; beat step is always 4 bytes.
- `s_axi_awburst`/`s_axi_arburst` in 2: 00 FIXED, 01 INCR; 10 WRAP is treated as INCR.
- `s_axi_awregion`/`s_axi_arregion` in 4, `s_axi_awcache`/`s_axi_arcache` in 4, `s_axi_awprot`/`s_axi_arprot` in 3: accepted and ignored.
- `s_axi_wvalid` in 1, `s_axi_wready` out 1, `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wlast` in 1: write data channel.
- `s_axi_bvalid` out 1, `s_axi_bready` in 1, `s_axi_bid` out ID_WIDTH, `s_axi_bresp` out 2: write response channel.
- `s_axi_rvalid` out 1, `s_axi_rready` in 1, `s_axi_rdata` out 32, `s_axi_rid` out ID_WIDTH, `s_axi_rlast` out 1, `s_axi_rresp` out 2: read data channel.
- `slide_switches` in 16: asynchronous board switches.
- `leds` out 16: LED register value.
- `irq` out 1: registered `|(IRQ_STATUS & IRQ_ENABLE)`.

## Operation
- **Register map** (decoded from offset [3:2]):
  - 0x0 `LED`: RW, bits [15:0], byte-strobed.
  - 0x4 `SW`: RO, synchronized (optionally debounced) switch value.
  - 0x8 `IRQ_STATUS`: a bit sets on any change of the corresponding `SW` bit; writing 1 clears the bit.
  - 0xC `IRQ_ENABLE`: RW, bits [15:0].
  - Bits [31:16] read as 0 in all registers.
- **Decode error:** any beat whose address has a nonzero bit in [ADDR_WIDTH-1:4] gets SLVERR. Error writes are dropped; error reads return 0.
- **Write FSM** (W_IDLE → W_DATA → W_RESP):
  - W_IDLE: `awready`=1; on AW handshake, capture id/addr/len/burst.
  - W_DATA: `wready`=1; each W handshake writes one beat, then the address advances by 4 (INCR) or holds (FIXED). Register index wraps modulo 4 inside the window.
  - The `wlast` beat moves the FSM to W_RESP.
  - W_RESP: `bvalid`=1 until `bready`, then W_IDLE.
  - `bresp`: SLVERR if any beat errored or the beat count ≠ len+1; OKAY otherwise.
- **Read FSM** (R_IDLE → R_DATA):
  - R_IDLE: `arready`=1; on AR handshake, capture id/addr/len/burst.
  - R_DATA: `rvalid`=1 with beat data. Each R handshake loads the next beat, with the same address stepping rule as writes.
  - `rlast` is asserted on beat len; after its handshake, return to R_IDLE.
  - `rresp` is set per beat. Reading `IRQ_STATUS` does not clear it.
- **Channel concurrency:** read and write channels run independently.
- **Simultaneous events:**
  - A hardware set and a W1C on the same `IRQ_STATUS` bit in the same cycle: set wins.
  - A read beat concurrent with a write to the same register returns the pre-write value.

## Timing
- **Reset values:** all outputs are 0 while `resetn` is low, including `awready`, `arready` and `leds`. `awready`/`arready` rise the first cycle after release.
- **Write path:**
  - AW handshake → `wready` the next cycle.
  - W handshake → register updated at that edge; `leds` visible the next cycle.
  - `wlast` handshake → `bvalid` the next cycle.
  - `bready` handshake → `awready` the next cycle.
  - Sustained W rate: 1 beat per cycle.
- **Read path:**
  - AR handshake → `rvalid` with beat 0 the next cycle.
  - Back-to-back beats at 1 per cycle while `rready`=1.
  - Last-beat handshake → `arready` the next cycle.
- **Switch and interrupt path:**
  - Switch edge → `SW` update 2 cycles later (without debounce).
  - `IRQ_STATUS` sets 1 cycle after the `SW` change.
  - `irq` follows 1 cycle after that.
- **Reset mid-burst:** FSMs return to IDLE and registers clear; no response is issued for the aborted transaction.

## Configuration
- `GPIO_DEBOUNCE_EN` defined:
  - Each synchronized bit must hold a new value for `DEBOUNCE_CYCLES` consecutive cycles before `SW` updates.
  - The per-bit counter restarts on any toggle.
- `GPIO_DEBOUNCE_EN` undefined: `SW` is the two-flop synchronizer output, and `DEBOUNCE_CYCLES` is unused.

## Structure
- **Package `axi_gpio_pkg`:**
  - register offsets (`LED_OFF`, `SW_OFF`, `IRQ_STATUS_OFF`, `IRQ_ENABLE_OFF`);
  - burst encodings (FIXED/INCR/WRAP);
  - response codes (OKAY=00, SLVERR=10);
  - write and read FSM state enums.
- **Sub-module `gpio_debounce`:** synchronizer plus optional debounce, WIDTH=16, instantiated once.

## Test plan
- Single write of 0x0000A5A5, wstrb 0xF, to 0x0 → `leds`=0xA5A5, `bresp`=OKAY, `bid` equals `awid`. Then a write of 0x00FF00FF with wstrb 0x1 → `leds`=0xA5FF.
- INCR read, len 3, at 0x0 → 4 beats returning LED, SW, IRQ_STATUS, IRQ_ENABLE, with `rlast` only on beat 3. With `rready` held, beats arrive on consecutive cycles.
- FIXED write, len 2, to 0xC with data 1, 2, 3 → `IRQ_ENABLE`=3 and `bresp`=OKAY.
- `IRQ_ENABLE`=0x0001, toggle `slide_switches`[0] → `irq`=1 within 4 cycles. Writing 0x1 to 0x8 → `irq`=0. A toggle coinciding with the clear leaves the bit set.
- Read at 0x20 → `rdata`=0 with SLVERR. Write at 0x20 → `bresp`=SLVERR and `leds` unchanged.
- Assert `resetn` mid read burst → `rvalid`=0 and `leds`=0; a fresh single read after release completes with OKAY.
